// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory request arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BSEL_W = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
    typedef enum logic {OWN_IFU, OWN_LSU} arb_owner_e;

    // Command latched at grant time and presented to the MMU
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BSEL_W-1:0] bytesel;
        logic [DATA_W-1:0] wdata;
        logic              rw;
    } mmu_cmd_t;

    localparam logic [BSEL_W-1:0] IFU_BYTESEL = 4'hF;
    localparam mmu_cmd_t          CMD_RST     = '0;
    localparam logic [DATA_W-1:0] DATA_RST    = '0;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Requester and MMU-side signals of the arbiter, bundled for port connection.
interface mem_req_arbiter_if;
    import mem_arb_pkg::*;

    logic              ifu_req;
    logic [ADDR_W-1:0] ifu_addr;
    logic [DATA_W-1:0] ifu_rdata;
    logic              ifu_done;
    logic              ifu_err;

    logic              lsu_req;
    logic              lsu_we;
    logic [ADDR_W-1:0] lsu_addr;
    logic [BSEL_W-1:0] lsu_bytesel;
    logic [DATA_W-1:0] lsu_wdata;
    logic [DATA_W-1:0] lsu_rdata;
    logic              lsu_done;
    logic              lsu_err;

    logic [ADDR_W-1:0] mmu_address;
    logic [BSEL_W-1:0] mmu_bytesel;
    logic [DATA_W-1:0] mmu_dat_in;
    logic              mmu_read_or_write;
    logic              mmu_retrieve;
    logic [DATA_W-1:0] mmu_dat_out;
    logic              mmu_complete;

    modport master (
        input  ifu_req, ifu_addr, lsu_req, lsu_we, lsu_addr, lsu_bytesel, lsu_wdata,
               mmu_dat_out, mmu_complete,
        output ifu_rdata, ifu_done, ifu_err, lsu_rdata, lsu_done, lsu_err,
               mmu_address, mmu_bytesel, mmu_dat_in, mmu_read_or_write, mmu_retrieve
    );

    modport slave (
        output ifu_req, ifu_addr, lsu_req, lsu_we, lsu_addr, lsu_bytesel, lsu_wdata,
               mmu_dat_out, mmu_complete,
        input  ifu_rdata, ifu_done, ifu_err, lsu_rdata, lsu_done, lsu_err,
               mmu_address, mmu_bytesel, mmu_dat_in, mmu_read_or_write, mmu_retrieve
    );

endinterface

// File: rtl/mem_req_arbiter_pick.sv
// Grant decision between IFU and LSU with a saturating LSU streak counter
// that forces an IFU grant after LSU_STREAK_MAX consecutive LSU wins.
module mem_arb_pick #(
    parameter int unsigned LSU_STREAK_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic grant_en,
    input  logic ifu_req,
    input  logic lsu_req,
    output logic grant_ifu_c,
    output logic grant_lsu_c
);
    localparam int unsigned STREAK_W = $clog2(LSU_STREAK_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_SAT = STREAK_W'(LSU_STREAK_MAX);

    logic [STREAK_W-1:0] streak_q;
    logic                ifu_forced;

    always_comb begin
        ifu_forced  = ifu_req && (streak_q == STREAK_SAT);
        grant_lsu_c = grant_en && lsu_req && !ifu_forced;
        grant_ifu_c = grant_en && ifu_req && !grant_lsu_c;
    end

    // Only LSU wins that starve a pending IFU extend the streak
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else if (grant_lsu_c && ifu_req) begin
            if (streak_q != STREAK_SAT) streak_q <= streak_q + STREAK_W'(1);
        end else if (grant_lsu_c || grant_ifu_c) begin
            streak_q <= '0;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Single-port MMU arbiter: grants IFU or LSU, runs the retrieve/complete
// handshake with a timeout, and returns data/status to the owner.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned LSU_STREAK_MAX = 4
) (
    input logic               soc_clk,
    input logic               soc_rst_n,
    mem_req_arbiter_if.master bus
);
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    mmu_cmd_t          cmd_q, cmd_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;
    logic              ifu_done_q, ifu_done_d, ifu_err_q, ifu_err_d;
    logic              lsu_done_q, lsu_done_d, lsu_err_q, lsu_err_d;
    logic              retrieve_q, retrieve_d;
    logic              to_resp, resp_err;
    logic [DATA_W-1:0] resp_data;
    logic              grant_ifu_c, grant_lsu_c;

    mem_arb_pick #(
        .LSU_STREAK_MAX(LSU_STREAK_MAX)
    ) u_pick (
        .clk        (soc_clk),
        .rst_n      (soc_rst_n),
        .grant_en   (state_q == IDLE),
        .ifu_req    (bus.ifu_req),
        .lsu_req    (bus.lsu_req),
        .grant_ifu_c(grant_ifu_c),
        .grant_lsu_c(grant_lsu_c)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cmd_d       = cmd_q;
        to_cnt_d    = to_cnt_q;
        ifu_rdata_d = ifu_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
        ifu_done_d  = 1'b0;
        ifu_err_d   = 1'b0;
        lsu_done_d  = 1'b0;
        lsu_err_d   = 1'b0;
        retrieve_d  = 1'b0;
        to_resp     = 1'b0;
        resp_err    = 1'b0;
        resp_data   = DATA_RST;

        unique case (state_q)
            IDLE: begin
                // Malformed requests are answered with err without touching the MMU
                if (grant_lsu_c) begin
                    owner_d = OWN_LSU;
                    if (bus.lsu_bytesel == '0) begin
                        to_resp  = 1'b1;
                        resp_err = 1'b1;
                    end else begin
                        cmd_d.addr    = bus.lsu_addr;
                        cmd_d.bytesel = bus.lsu_bytesel;
                        cmd_d.wdata   = bus.lsu_wdata;
                        cmd_d.rw      = bus.lsu_we;
                        state_d       = ISSUE;
                        retrieve_d    = 1'b1;
                    end
                end else if (grant_ifu_c) begin
                    owner_d = OWN_IFU;
                    if (bus.ifu_addr[1:0] != 2'b00) begin
                        to_resp  = 1'b1;
                        resp_err = 1'b1;
                    end else begin
                        cmd_d.addr    = bus.ifu_addr;
                        cmd_d.bytesel = IFU_BYTESEL;
                        cmd_d.wdata   = DATA_RST;
                        cmd_d.rw      = 1'b0;
                        state_d       = ISSUE;
                        retrieve_d    = 1'b1;
                    end
                end
            end
            ISSUE: begin
                to_cnt_d = '0;
                if (bus.mmu_complete) begin
                    to_resp   = 1'b1;
                    resp_data = bus.mmu_dat_out;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.mmu_complete) begin
                    to_resp   = 1'b1;
                    resp_data = bus.mmu_dat_out;
                end else if (to_cnt_q == TO_LAST) begin
                    to_resp  = 1'b1;
                    resp_err = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Route completion to whichever requester owns this transaction
        if (to_resp) begin
            state_d = RESP;
            if (owner_d == OWN_IFU) begin
                ifu_done_d  = 1'b1;
                ifu_err_d   = resp_err;
                ifu_rdata_d = resp_data;
            end else begin
                lsu_done_d  = 1'b1;
                lsu_err_d   = resp_err;
                lsu_rdata_d = resp_data;
            end
        end
    end

    always_ff @(posedge soc_clk or negedge soc_rst_n) begin
        if (!soc_rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IFU;
            cmd_q       <= CMD_RST;
            to_cnt_q    <= '0;
            ifu_rdata_q <= DATA_RST;
            lsu_rdata_q <= DATA_RST;
            ifu_done_q  <= 1'b0;
            ifu_err_q   <= 1'b0;
            lsu_done_q  <= 1'b0;
            lsu_err_q   <= 1'b0;
            retrieve_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cmd_q       <= cmd_d;
            to_cnt_q    <= to_cnt_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
            ifu_done_q  <= ifu_done_d;
            ifu_err_q   <= ifu_err_d;
            lsu_done_q  <= lsu_done_d;
            lsu_err_q   <= lsu_err_d;
            retrieve_q  <= retrieve_d;
        end
    end

    assign bus.mmu_address       = cmd_q.addr;
    assign bus.mmu_bytesel       = cmd_q.bytesel;
    assign bus.mmu_dat_in        = cmd_q.wdata;
    assign bus.mmu_read_or_write = cmd_q.rw;
    assign bus.mmu_retrieve      = retrieve_q;
    assign bus.ifu_rdata         = ifu_rdata_q;
    assign bus.ifu_done          = ifu_done_q;
    assign bus.ifu_err           = ifu_err_q;
    assign bus.lsu_rdata         = lsu_rdata_q;
    assign bus.lsu_done          = lsu_done_q;
    assign bus.lsu_err           = lsu_err_q;

endmodule
